decode_in_capture_monitor: RTL and testbench

//  Synthesisable, parametrised capture monitor for the decode-stage input bus.

---
 rtl/decode_in_capture_monitor.sv | 154 +++++++++++++++
 tb/tb_decode_in_capture_monitor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_in_capture_monitor.sv
// decode_in_capture_monitor: capture monitor for the decode-stage input bus.
// After a start pulse and a settle delay of SKIP_CYCLES edges, every cycle with
// en_decode high is sampled into a first-word-fall-through FIFO and offered to a
// consumer over txn_valid/txn_ready. The monitor never back-pressures the bus;
// samples arriving while the FIFO is full are dropped and flagged in overflow.
// Optional feature: define DECODE_IN_MON_TIMESTAMP_EN to store a free-running
// cycle count with each entry, presented on txn_time.
module decode_in_capture_monitor #(
   parameter int unsigned INSTR_W     = 16,
   parameter int unsigned NPC_W       = 16,
   parameter int unsigned SR_W        = 3,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned SKIP_CYCLES = 6,
   parameter int unsigned TS_W        = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       en_decode,
   input  logic [INSTR_W-1:0]         instr_dout,
   input  logic [NPC_W-1:0]           npc_in,
   input  logic [SR_W-1:0]            Sr,
   output logic                       txn_valid,
   input  logic                       txn_ready,
   output logic [INSTR_W-1:0]         txn_instr,
   output logic [NPC_W-1:0]           txn_npc,
   output logic [SR_W-1:0]            txn_sr,
`ifdef DECODE_IN_MON_TIMESTAMP_EN
   output logic [TS_W-1:0]            txn_time,
`endif
   output logic                       armed,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow
);

   localparam int unsigned PTR_W     = $clog2(DEPTH);
   localparam int unsigned LVL_W     = PTR_W + 1;
   localparam int unsigned CNT_W     = (SKIP_CYCLES > 0) ? $clog2(SKIP_CYCLES + 1) : 1;
   localparam int unsigned SKIP_LAST = (SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0;
   localparam int unsigned DATA_W    = INSTR_W + NPC_W + SR_W;
`ifdef DECODE_IN_MON_TIMESTAMP_EN
   localparam int unsigned ENTRY_W   = DATA_W + TS_W;
`else
   // no timestamp field is stored in this build
   localparam int unsigned ENTRY_W   = DATA_W + 0 * TS_W;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_SKIP,
      S_MONITOR
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [LVL_W-1:0]   r_wr, r_rd;
   logic               r_overflow;
   logic [LVL_W-1:0]   w_level;
   logic               w_sample, w_full, w_empty, w_pop, w_push;
   logic [ENTRY_W-1:0] w_entry, w_head;

`ifdef DECODE_IN_MON_TIMESTAMP_EN
   logic [TS_W-1:0]    r_ts;

   // free-running cycle counter, wraps naturally
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_ts <= '0;
      else       r_ts <= r_ts + TS_W'(1);
   end

   assign w_entry = {instr_dout, npc_in, Sr, r_ts};
`else
   assign w_entry = {instr_dout, npc_in, Sr};
`endif

   // FSM state and settle counter registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // next-state: count SKIP_CYCLES edges after start, then monitor until reset
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_cnt_nxt = '0;
               if (SKIP_CYCLES == 0) w_state_nxt = S_MONITOR;
               else                  w_state_nxt = S_SKIP;
            end
         end
         S_SKIP: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(SKIP_LAST)) w_state_nxt = S_MONITOR;
         end
         S_MONITOR: ;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // sample qualifier: an unknown en_decode falls to the no-push branch
   always_comb begin
      w_sample = 1'b0;
      if (r_state == S_MONITOR) begin
         if (en_decode) w_sample = 1'b1;
      end
   end

   assign w_level = r_wr - r_rd;
   assign w_empty = (r_wr == r_rd);
   assign w_full  = (w_level == LVL_W'(DEPTH));
   assign w_pop   = !w_empty && txn_ready;
   assign w_push  = w_sample && (!w_full || w_pop);

   // FIFO pointers and sticky overflow flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr       <= '0;
         r_rd       <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr <= r_wr + LVL_W'(1);
         if (w_pop)  r_rd <= r_rd + LVL_W'(1);
         if (w_sample && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   // FIFO storage; contents are masked at the outputs while empty
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr[PTR_W-1:0]] <= w_entry;
   end

   assign w_head = w_empty ? '0 : r_mem[r_rd[PTR_W-1:0]];

`ifdef DECODE_IN_MON_TIMESTAMP_EN
   assign {txn_instr, txn_npc, txn_sr, txn_time} = w_head;
`else
   assign {txn_instr, txn_npc, txn_sr} = w_head;
`endif

   assign txn_valid = !w_empty;
   assign armed     = (r_state == S_MONITOR);
   assign level     = w_level;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_decode_in_capture_monitor.sv
// Scoreboard bench for decode_in_capture_monitor (DEPTH=8, SKIP_CYCLES=6).
// Stimulus pushes hand-derived expected entries; a negedge monitor pops and
// compares whenever the DUT hands over an entry (txn_valid & txn_ready).
module tb_decode_in_capture_monitor;

   logic        clock = 1'b0;
   logic        reset, start, en_decode, txn_ready;
   logic [15:0] instr_dout, npc_in;
   logic [2:0]  Sr;
   logic        txn_valid, armed, overflow;
   logic [15:0] txn_instr, txn_npc;
   logic [2:0]  txn_sr;
   logic [3:0]  level;
`ifdef DECODE_IN_MON_TIMESTAMP_EN
   logic [31:0] txn_time;
`endif

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] npc;
      logic [2:0]  sr;
      logic [31:0] ts;
   } txn_t;

   txn_t        exp_q[$];
   txn_t        mon_e;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] tb_ts;

   decode_in_capture_monitor #(
      .INSTR_W(16), .NPC_W(16), .SR_W(3), .DEPTH(8), .SKIP_CYCLES(6), .TS_W(32)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .en_decode(en_decode),
      .instr_dout(instr_dout), .npc_in(npc_in), .Sr(Sr),
      .txn_valid(txn_valid), .txn_ready(txn_ready),
      .txn_instr(txn_instr), .txn_npc(txn_npc), .txn_sr(txn_sr),
`ifdef DECODE_IN_MON_TIMESTAMP_EN
      .txn_time(txn_time),
`endif
      .armed(armed), .level(level), .overflow(overflow)
   );

   always #5 clock = ~clock;

   // reference cycle count: 0 in reset, +1 on every edge afterwards
   always @(posedge clock or posedge reset) begin
      if (reset) tb_ts <= 32'd0;
      else       tb_ts <= tb_ts + 32'd1;
   end

   // monitor: compare each handed-over entry against the scoreboard head
   always @(negedge clock) begin
      if (reset === 1'b0 && txn_valid === 1'b1 && txn_ready === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_txn: got instr=%h npc=%h sr=%b, required no entry",
                     txn_instr, txn_npc, txn_sr);
         end else begin
            mon_e = exp_q.pop_front();
            if (txn_instr !== mon_e.instr || txn_npc !== mon_e.npc || txn_sr !== mon_e.sr
`ifdef DECODE_IN_MON_TIMESTAMP_EN
                || txn_time !== mon_e.ts
`endif
               ) begin
               n_err++;
               $display("FAIL txn_data: got instr=%h npc=%h sr=%b, required instr=%h npc=%h sr=%b ts=%0d",
                        txn_instr, txn_npc, txn_sr, mon_e.instr, mon_e.npc, mon_e.sr, mon_e.ts);
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] v_instr(input int k);
      return 16'(32'hA000 + k);
   endfunction

   function automatic logic [15:0] v_npc(input int k);
      return 16'(32'h3000 + 2 * k);
   endfunction

   function automatic logic [2:0] v_sr(input int k);
      return 3'(k);
   endfunction

   task automatic drive(input int k, input logic en);
      instr_dout = v_instr(k);
      npc_in     = v_npc(k);
      Sr         = v_sr(k);
      en_decode  = en;
   endtask

   // expected entry for the sample taken at the coming edge
   task automatic expect_k(input int k);
      txn_t e;
      e.instr = v_instr(k);
      e.npc   = v_npc(k);
      e.sr    = v_sr(k);
      e.ts    = tb_ts;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      txn_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
      step();
      txn_ready = 1'b0;
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_level", 32'(level), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t e;
      reset = 1'b1; start = 1'b0; txn_ready = 1'b0;
      drive(0, 1'b0);
      step(); step();
      check("rst_valid", 32'(txn_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_armed", 32'(armed), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_instr", 32'(txn_instr), 32'd0);
      reset = 1'b0;
      step();

      // settle delay: edges 1..6 ignored, edge 7 sampled
      drive(100, 1'b1); start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         drive(100 + i, 1'b1);
         step();
         check("skip_level", 32'(level), 32'd0);
         check("skip_armed", 32'(armed), (i == 6) ? 32'd1 : 32'd0);
      end
      drive(107, 1'b1); expect_k(107);
      step();
      en_decode = 1'b0;
      check("first_level", 32'(level), 32'd1);
      drain();

      // single sample, field order
      instr_dout = 16'h1234; npc_in = 16'h3001; Sr = 3'b010; en_decode = 1'b1;
      txn_ready = 1'b1;
      e.instr = 16'h1234; e.npc = 16'h3001; e.sr = 3'b010; e.ts = tb_ts;
      exp_q.push_back(e);
      step();
      en_decode = 1'b0;
      check("single_valid", 32'(txn_valid), 32'd1);
      step();
      check("single_gone", 32'(txn_valid), 32'd0);
      txn_ready = 1'b0;

      // nine samples into eight entries: ninth dropped
      for (int k = 0; k < 9; k++) begin
         drive(200 + k, 1'b1);
         if (k < 8) expect_k(200 + k);
         step();
      end
      en_decode = 1'b0;
      check("full_level", 32'(level), 32'd8);
      check("full_overflow", 32'(overflow), 32'd1);
      drain();
      check("overflow_sticky", 32'(overflow), 32'd1);

      // reset mid-stream with five entries queued
      for (int k = 0; k < 5; k++) begin
         drive(300 + k, 1'b1); expect_k(300 + k);
         step();
      end
      en_decode = 1'b0;
      check("mid_level", 32'(level), 32'd5);
      reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(txn_valid), 32'd0);
      check("mid_rst_level", 32'(level), 32'd0);
      check("mid_rst_armed", 32'(armed), 32'd0);
      exp_q.delete();
      step();
      reset = 1'b0;
      check("mid_rst_overflow", 32'(overflow), 32'd0);
      drive(400, 1'b1);
      step(); step(); step();
      check("no_start_level", 32'(level), 32'd0);
      check("no_start_armed", 32'(armed), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         drive(400 + i, 1'b1);
         step();
         check("reskip_level", 32'(level), 32'd0);
      end
      drive(407, 1'b1); expect_k(407);
      step();
      en_decode = 1'b0;
      check("rearm_level", 32'(level), 32'd1);
      drain();

      // full FIFO with simultaneous push and pop
      for (int k = 0; k < 8; k++) begin
         drive(500 + k, 1'b1); expect_k(500 + k);
         step();
      end
      en_decode = 1'b0;
      check("fill8_level", 32'(level), 32'd8);
      check("fill8_overflow", 32'(overflow), 32'd0);
      drive(508, 1'b1); expect_k(508);
      txn_ready = 1'b1;
      step();
      en_decode = 1'b0; txn_ready = 1'b0;
      check("pushpop_level", 32'(level), 32'd8);
      check("pushpop_overflow", 32'(overflow), 32'd0);
      check("pushpop_head", 32'(txn_instr), 32'(v_instr(501)));
      drain();

      // two samples three edges apart (timestamps checked when enabled)
      drive(600, 1'b1); expect_k(600);
      step();
      en_decode = 1'b0;
      step(); step();
      drive(601, 1'b1); expect_k(601);
      step();
      en_decode = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
